// File: rtl/i2c_target_if.sv
`default_nettype none
// ============================================================================
// Module   : i2c_target_if
// Brief    : Clock-domain side of the I2C target: sclk plus the byte handshake.
// Revision : 1.0
// ============================================================================
interface i2c_target_if;
    logic       sclk;
    logic [7:0] tx_data;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_load;
    logic       busy;

    modport slave  (input  sclk, input  tx_data,
                    output rx_data, output rx_valid, output tx_load, output busy);
    modport master (output sclk, output tx_data,
                    input  rx_data, input  rx_valid, input  tx_load, input  busy);
endinterface
`default_nettype wire

// File: rtl/i2c_target.sv
`default_nettype none
// ============================================================================
// Module   : i2c_target
// Brief    : Oversampled 7-bit-address I2C target with single-byte handshake.
// Revision : 1.0
// ============================================================================
module i2c_target #(
    parameter logic [6:0] TARGET_ADDR = 7'h39
) (
    input  logic            clk,
    input  logic            rst_n,
    inout  wire             sda,
    i2c_target_if.slave     bus
);
    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_ADDR      = 3'd1;
    localparam logic [2:0] c_ADDR_ACK  = 3'd2;
    localparam logic [2:0] c_WRITE     = 3'd3;
    localparam logic [2:0] c_WRITE_ACK = 3'd4;
    localparam logic [2:0] c_READ      = 3'd5;
    localparam logic [2:0] c_READ_ACK  = 3'd6;
    localparam logic [2:0] c_WAIT_STOP = 3'd7;

    logic [1:0] scl_sync_q, sda_sync_q;
    logic       scl_prev_q, sda_prev_q;
    logic [2:0] state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rw_q, rw_d;
    logic       mack_q, mack_d;
    logic       drive_q, drive_d;
    logic       busy_q, busy_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_load_q, tx_load_d;

    logic       w_scl, w_sda, w_rise, w_fall, w_start, w_stop;
    logic [7:0] w_byte;

    assign w_scl   = scl_sync_q[1];
    assign w_sda   = sda_sync_q[1];
    assign w_rise  = w_scl & ~scl_prev_q;
    assign w_fall  = ~w_scl & scl_prev_q;
    // sclk must be high on both samples so a data change next to an sclk edge is not a START/STOP
    assign w_start = w_scl & scl_prev_q & sda_prev_q & ~w_sda;
    assign w_stop  = w_scl & scl_prev_q & ~sda_prev_q & w_sda;
    assign w_byte  = {shift_q[6:0], w_sda};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], bus.sclk};
            sda_sync_q <= {sda_sync_q[0], sda};
            scl_prev_q <= scl_sync_q[1];
            sda_prev_q <= sda_sync_q[1];
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        tx_shift_d = tx_shift_q;
        rx_data_d  = rx_data_q;
        rw_d       = rw_q;
        mack_d     = mack_q;
        drive_d    = drive_q;
        busy_d     = busy_q;
        rx_valid_d = 1'b0;
        tx_load_d  = 1'b0;
        if (w_start) begin
            state_d   = c_ADDR;
            bit_cnt_d = 3'd0;
            drive_d   = 1'b0;
            mack_d    = 1'b0;
        end else if (w_stop) begin
            state_d   = c_IDLE;
            bit_cnt_d = 3'd0;
            drive_d   = 1'b0;
            busy_d    = 1'b0;
            mack_d    = 1'b0;
        end else begin
            case (state_q)
                c_ADDR: if (w_rise) begin
                    shift_d   = w_byte;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        if (w_byte[7:1] == TARGET_ADDR) begin
                            state_d = c_ADDR_ACK;
                            busy_d  = 1'b1;
                            rw_d    = w_byte[0];
                        end else begin
                            state_d = c_WAIT_STOP;
                        end
                    end
                end
                // ACK is held for one full sclk low-high-low: first fall grabs, second releases
                c_ADDR_ACK: if (w_fall) begin
                    if (!drive_q) begin
                        drive_d = 1'b1;
                    end else if (rw_q) begin
                        state_d    = c_READ;
                        tx_load_d  = 1'b1;
                        tx_shift_d = bus.tx_data;
                        drive_d    = ~bus.tx_data[7];
                        bit_cnt_d  = 3'd0;
                    end else begin
                        state_d = c_WRITE;
                        drive_d = 1'b0;
                    end
                end
                c_WRITE: if (w_rise) begin
                    shift_d   = w_byte;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rx_data_d  = w_byte;
                        rx_valid_d = 1'b1;
                        state_d    = c_WRITE_ACK;
                    end
                end
                c_WRITE_ACK: if (w_fall) begin
                    if (!drive_q) begin
                        drive_d = 1'b1;
                    end else begin
                        drive_d = 1'b0;
                        state_d = c_WRITE;
                    end
                end
                // A fall with the counter back at 0 can only follow the eighth rise
                c_READ: if (w_rise) begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end else if (w_fall) begin
                    if (bit_cnt_q == 3'd0) begin
                        drive_d = 1'b0;
                        state_d = c_READ_ACK;
                    end else begin
                        drive_d = ~tx_shift_q[3'd7 - bit_cnt_q];
                    end
                end
                c_READ_ACK: if (w_rise) begin
                    if (w_sda) state_d = c_WAIT_STOP;
                    else       mack_d  = 1'b1;
                end else if (w_fall && mack_q) begin
                    mack_d     = 1'b0;
                    state_d    = c_READ;
                    tx_load_d  = 1'b1;
                    tx_shift_d = bus.tx_data;
                    drive_d    = ~bus.tx_data[7];
                    bit_cnt_d  = 3'd0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= c_IDLE;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'h00;
            tx_shift_q <= 8'h00;
            rx_data_q  <= 8'h00;
            rw_q       <= 1'b0;
            mack_q     <= 1'b0;
            drive_q    <= 1'b0;
            busy_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            tx_load_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tx_shift_q <= tx_shift_d;
            rx_data_q  <= rx_data_d;
            rw_q       <= rw_d;
            mack_q     <= mack_d;
            drive_q    <= drive_d;
            busy_q     <= busy_d;
            rx_valid_q <= rx_valid_d;
            tx_load_q  <= tx_load_d;
        end
    end

    assign sda          = drive_q ? 1'b0 : 1'bz;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.tx_load  = tx_load_q;
    assign bus.busy     = busy_q;
endmodule
`default_nettype wire

// File: tb/tb_i2c_target.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_target
// Brief    : Directed bit-banged I2C master exercising write, read and abort cases.
// Revision : 1.0
// ============================================================================
module tb_i2c_target;
    logic clk = 1'b0;
    logic rst_n;
    logic m_low;
    wire  sda;

    i2c_target_if bus();

    pullup (sda);
    assign sda = m_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_target #(.TARGET_ADDR(7'h39)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sda   (sda),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int rxv_cnt  = 0;
    int txl_cnt  = 0;
    int drove_cnt = 0;

    always @(negedge clk) begin
        if (bus.rx_valid) rxv_cnt++;
        if (bus.tx_load)  txl_cnt++;
        if (!m_low && sda == 1'b0) drove_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic q();
        repeat (10) @(posedge clk);
    endtask

    // Works as both START (from idle) and repeated START (from sclk low)
    task automatic i2c_start();
        m_low = 1'b0; q();
        bus.sclk = 1'b1; q();
        m_low = 1'b1; q();
        bus.sclk = 1'b0; q();
    endtask

    task automatic i2c_stop();
        m_low = 1'b1; q();
        bus.sclk = 1'b1; q();
        m_low = 1'b0; q();
    endtask

    task automatic send_bit(input logic b);
        m_low = ~b; q();
        bus.sclk = 1'b1; q(); q();
        bus.sclk = 1'b0; q();
    endtask

    task automatic recv_bit(output logic b);
        m_low = 1'b0; q();
        bus.sclk = 1'b1; q();
        @(negedge clk);
        b = sda;
        q();
        bus.sclk = 1'b0; q();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(ack);
    endtask

    task automatic read_byte(input logic mack, input logic [7:0] next_tx, output logic [7:0] d);
        logic b;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            recv_bit(b);
            d = {d[6:0], b};
        end
        bus.tx_data = next_tx;
        send_bit(mack);
    endtask

    initial begin
        logic       ack;
        logic [7:0] d;
        int base_rxv, base_txl, base_drv;

        rst_n = 1'b0;
        m_low = 1'b0;
        bus.sclk = 1'b1;
        bus.tx_data = 8'h00;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_rx_data",  bus.rx_data,  8'h00);
        check("rst_rx_valid", bus.rx_valid, 1'b0);
        check("rst_tx_load",  bus.tx_load,  1'b0);
        check("rst_busy",     bus.busy,     1'b0);
        check("rst_sda",      sda,          1'b1);
        rst_n = 1'b1;
        q();

        // Write 0xA5 to address 0x39
        base_rxv = rxv_cnt;
        i2c_start();
        write_byte(8'h72, ack); check("wr_addr_ack", ack, 1'b0);
        check("wr_busy", bus.busy, 1'b1);
        write_byte(8'hA5, ack); check("wr_data_ack", ack, 1'b0);
        check("wr_rx_data", bus.rx_data, 8'hA5);
        i2c_stop();
        check("wr_rxv_cnt", rxv_cnt - base_rxv, 1);
        check("wr_busy_stop", bus.busy, 1'b0);

        // Single-byte read of 0x3C with NACK
        bus.tx_data = 8'h3C;
        base_txl = txl_cnt;
        i2c_start();
        write_byte(8'h73, ack); check("rd_addr_ack", ack, 1'b0);
        read_byte(1'b1, 8'h00, d);
        check("rd_data", d, 8'h3C);
        check("rd_busy_wait", bus.busy, 1'b1);
        i2c_stop();
        check("rd_txl_cnt", txl_cnt - base_txl, 1);
        check("rd_busy_stop", bus.busy, 1'b0);

        // Foreign address: no ACK, no drive, no pulses
        base_rxv = rxv_cnt; base_txl = txl_cnt; base_drv = drove_cnt;
        i2c_start();
        write_byte(8'h54, ack); check("na_ack", ack, 1'b1);
        check("na_busy", bus.busy, 1'b0);
        write_byte(8'h00, ack); check("na_ack2", ack, 1'b1);
        i2c_stop();
        check("na_drove", drove_cnt - base_drv, 0);
        check("na_rxv", rxv_cnt - base_rxv, 0);
        check("na_txl", txl_cnt - base_txl, 0);

        // Write, repeated START, two-byte read
        bus.tx_data = 8'h5A;
        base_txl = txl_cnt;
        i2c_start();
        write_byte(8'h72, ack); check("rs_wr_ack", ack, 1'b0);
        write_byte(8'h11, ack); check("rs_wr_data_ack", ack, 1'b0);
        i2c_start();
        write_byte(8'h73, ack); check("rs_rd_ack", ack, 1'b0);
        read_byte(1'b0, 8'hC3, d); check("rs_rd_b0", d, 8'h5A);
        read_byte(1'b1, 8'h00, d); check("rs_rd_b1", d, 8'hC3);
        i2c_stop();
        check("rs_rx_data", bus.rx_data, 8'h11);
        check("rs_txl_cnt", txl_cnt - base_txl, 2);
        check("rs_busy", bus.busy, 1'b0);

        // Reset while the target drives a 0 read bit
        bus.tx_data = 8'h3C;
        i2c_start();
        write_byte(8'h73, ack); check("mr_addr_ack", ack, 1'b0);
        @(negedge clk);
        check("mr_bit_driven", sda, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mr_sda_rel", sda, 1'b1);
        check("mr_busy", bus.busy, 1'b0);
        check("mr_rx_data", bus.rx_data, 8'h00);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        base_drv = drove_cnt;
        m_low = 1'b0; bus.sclk = 1'b1; q(); q();
        check("mr_idle_busy", bus.busy, 1'b0);
        check("mr_idle_drove", drove_cnt - base_drv, 0);
        base_rxv = rxv_cnt;
        i2c_start();
        write_byte(8'h72, ack); check("mr_wr_ack", ack, 1'b0);
        write_byte(8'hA5, ack); check("mr_wr_data_ack", ack, 1'b0);
        i2c_stop();
        check("mr_rx_data2", bus.rx_data, 8'hA5);
        check("mr_rxv_cnt", rxv_cnt - base_rxv, 1);

        // STOP after four data bits
        base_rxv = rxv_cnt;
        i2c_start();
        write_byte(8'h72, ack); check("ps_addr_ack", ack, 1'b0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        i2c_stop();
        q();
        check("ps_rxv", rxv_cnt - base_rxv, 0);
        check("ps_rx_data", bus.rx_data, 8'hA5);
        check("ps_busy", bus.busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
